// File: rtl/icc_result_stage_pkg.sv
// Shared ALU definitions (package alu_pkg): opcodes, icc bit positions and
// the default datapath width. Imported by icc_calc, the stage interface and
// icc_result_stage.
package alu_pkg;

  localparam int DATA_W_DEFAULT = 32;

  // mini_alu opcodes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_ADDX = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_SUBX = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOTB = 4'b0111;

  // Positions inside the 4-bit {N,Z,V,C} icc vector
  localparam int ICC_N = 3;
  localparam int ICC_Z = 2;
  localparam int ICC_V = 1;
  localparam int ICC_C = 0;

endpackage

// File: rtl/icc_result_stage_if.sv
// Handshake/bus bundle between mini_alu (upstream), icc_result_stage and the
// MEM stage (downstream).
// Handshake: an upstream transfer happens on a rising edge where
// valid_i & ready_o & ~flush_i; a downstream transfer happens where
// valid_o & ready_i. valid must not depend on ready; ready_o never depends
// on valid_i.
interface icc_result_stage_if
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int RD_W   = 5
);
  // upstream side
  logic              valid_i;
  logic              ready_o;
  logic [DATA_W-1:0] a_i;
  logic [DATA_W-1:0] b_i;
  logic [DATA_W-1:0] y_i;
  logic [3:0]        op_i;
  logic              set_cc_i;
  logic [RD_W-1:0]   rd_i;
  logic              we_i;
  logic              flush_i;
  // downstream side
  logic              valid_o;
  logic              ready_i;
  logic [DATA_W-1:0] y_o;
  logic [RD_W-1:0]   rd_o;
  logic              we_o;
  // architectural flags
  logic [3:0]        icc_o;
  logic              c1_o;
  logic              trap_o;

  // master: the environment around the stage (ALU, pipeline control, MEM)
  modport master (
    output valid_i, a_i, b_i, y_i, op_i, set_cc_i, rd_i, we_i, flush_i, ready_i,
    input  ready_o, valid_o, y_o, rd_o, we_o, icc_o, c1_o, trap_o
  );

  // slave: the result stage itself
  modport slave (
    input  valid_i, a_i, b_i, y_i, op_i, set_cc_i, rd_i, we_i, flush_i, ready_i,
    output ready_o, valid_o, y_o, rd_o, we_o, icc_o, c1_o, trap_o
  );

endinterface

// File: rtl/icc_result_stage_icc_calc.sv
// icc_calc: purely combinational SPARC {N,Z,V,C} generator from ALU operands,
// result, opcode and carry-in. Carry/borrow come from a DATA_W+1 bit sum so
// the flag is exact regardless of what y the ALU produced.
module icc_calc
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] y_i,
  input  logic [3:0]        op_i,
  input  logic              cin_i,
  output logic [3:0]        flags_o
);

  logic [DATA_W:0] sum_w;
  logic [DATA_W:0] diff_w;
  logic            sign_a;
  logic            sign_b;
  logic            sign_y;
  logic            unused_low;

  assign sign_a = a_i[DATA_W-1];
  assign sign_b = b_i[DATA_W-1];
  assign sign_y = y_i[DATA_W-1];

  // Only the top (carry/borrow) bit of each wide result is a flag.
  assign unused_low = ^{sum_w[DATA_W-1:0], diff_w[DATA_W-1:0]};

  // Flag generation: N/Z from y for every opcode, V/C only for add/sub.
  always_comb begin
    sum_w   = {1'b0, a_i} + {1'b0, b_i} + {{DATA_W{1'b0}}, cin_i};
    diff_w  = {1'b0, a_i} - {1'b0, b_i} - {{DATA_W{1'b0}}, cin_i};
    flags_o = 4'b0000;
    flags_o[ICC_N] = sign_y;
    flags_o[ICC_Z] = (y_i == '0);
    case (op_i)
      ALU_ADD, ALU_ADDX: begin
        flags_o[ICC_C] = sum_w[DATA_W];
        flags_o[ICC_V] = (sign_a == sign_b) & (sign_y != sign_a);
      end
      ALU_SUB, ALU_SUBX: begin
        flags_o[ICC_C] = diff_w[DATA_W];
        flags_o[ICC_V] = (sign_a != sign_b) & (sign_y != sign_a);
      end
      default: begin
        flags_o[ICC_C] = 1'b0;
        flags_o[ICC_V] = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/icc_result_stage.sv
// icc_result_stage: single-entry EX/MEM register behind mini_alu plus the
// architectural icc register. The held C flag feeds back to the ALU carry
// input (c1_o). Optional overflow trap bit when ICC_OVF_TRAP_EN is defined;
// without it trap_o is constant 0.
module icc_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int RD_W   = 5
) (
  input  logic                Clk,
  input  logic                Clr,
  icc_result_stage_if.slave   bus
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              we_q, we_d;
  logic [3:0]        icc_q, icc_d;
  logic [3:0]        flags;
  logic              cin;
  logic              ready;
  logic              accept;

  // Only ADDX/SUBX consume the stored carry.
  assign cin    = ((bus.op_i == ALU_ADDX) || (bus.op_i == ALU_SUBX)) & icc_q[ICC_C];
  assign ready  = ~valid_q | bus.ready_i;
  assign accept = bus.valid_i & ready & ~bus.flush_i;

  icc_calc #(.DATA_W(DATA_W)) u_icc_calc (
    .a_i     (bus.a_i),
    .b_i     (bus.b_i),
    .y_i     (bus.y_i),
    .op_i    (bus.op_i),
    .cin_i   (cin),
    .flags_o (flags)
  );

  // Next-state: flush beats accept, accept replaces (even while retiring),
  // retire clears valid, otherwise hold. icc only moves on accept+set_cc.
  always_comb begin
    valid_d = valid_q;
    y_d     = y_q;
    rd_d    = rd_q;
    we_d    = we_q;
    icc_d   = icc_q;
    if (bus.flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      y_d     = bus.y_i;
      rd_d    = bus.rd_i;
      we_d    = bus.we_i;
      if (bus.set_cc_i) begin
        icc_d = flags;
      end
    end else if (bus.ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Entry and icc registers, cleared asynchronously.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      valid_q <= 1'b0;
      y_q     <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      icc_q   <= 4'b0000;
    end else begin
      valid_q <= valid_d;
      y_q     <= y_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      icc_q   <= icc_d;
    end
  end

`ifdef ICC_OVF_TRAP_EN
  logic trap_q, trap_d;
  logic is_arith;

  // Opcodes 0000-0011 are the add/sub family.
  assign is_arith = (bus.op_i[3:2] == 2'b00);

  // Trap bit travels with the entry: loaded on accept, held otherwise.
  always_comb begin
    trap_d = trap_q;
    if (accept) begin
      trap_d = bus.set_cc_i & is_arith & flags[ICC_V];
    end
  end

  // Trap storage, cleared asynchronously.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end

  assign bus.trap_o = trap_q & valid_q;
`else
  assign bus.trap_o = 1'b0;
`endif

  assign bus.ready_o = ready;
  assign bus.valid_o = valid_q;
  assign bus.y_o     = y_q;
  assign bus.rd_o    = rd_q;
  assign bus.we_o    = we_q;
  assign bus.icc_o   = icc_q;
  assign bus.c1_o    = icc_q[ICC_C];

endmodule

// File: tb/tb_icc_result_stage.sv
// Directed bench for icc_result_stage: inputs change #1 after the rising
// edge, outputs are compared #1 after the following rising edge.
module tb_icc_result_stage;

  logic Clk;
  logic Clr;
  int   n_vec;
  int   n_err;

`ifdef ICC_OVF_TRAP_EN
  localparam logic TRAP_ON = 1'b1;
`else
  localparam logic TRAP_ON = 1'b0;
`endif

  icc_result_stage_if #(.DATA_W(32), .RD_W(5)) bus ();

  icc_result_stage #(.DATA_W(32), .RD_W(5)) dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] y, input logic [3:0] op, input logic sc,
                       input logic [4:0] rd, input logic we);
    bus.valid_i  = v;
    bus.a_i      = a;
    bus.b_i      = b;
    bus.y_i      = y;
    bus.op_i     = op;
    bus.set_cc_i = sc;
    bus.rd_i     = rd;
    bus.we_i     = we;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0, 5'd0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    // reset held from time 0
    n_vec++;
    if ({bus.valid_o, bus.y_o, bus.rd_o, bus.we_o, bus.icc_o, bus.c1_o, bus.trap_o} !== 44'h0) begin
      n_err++;
      $display("FAIL rst_init: got valid=%b y=%h rd=%h we=%b icc=%b c1=%b trap=%b want all 0",
               bus.valid_o, bus.y_o, bus.rd_o, bus.we_o, bus.icc_o, bus.c1_o, bus.trap_o);
    end
    @(negedge Clk);
    Clr = 1'b1;
    // load an overflow entry, then stall it
    bus.ready_i = 1'b0;
    drive(1'b1, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b0000, 1'b1, 5'd9, 1'b1);
    step();
    n_vec++;
    if (bus.valid_o !== 1'b1 || bus.icc_o !== 4'b1010) begin
      n_err++;
      $display("FAIL rst_preload: got valid=%b icc=%b want 1/1010", bus.valid_o, bus.icc_o);
    end
    idle();
    step();
    // asynchronous reset mid-stall
    #2;
    Clr = 1'b0;
    #1;
    n_vec++;
    if ({bus.valid_o, bus.y_o, bus.rd_o, bus.we_o, bus.icc_o, bus.c1_o, bus.trap_o} !== 44'h0) begin
      n_err++;
      $display("FAIL rst_async: got valid=%b y=%h rd=%h we=%b icc=%b c1=%b trap=%b want all 0",
               bus.valid_o, bus.y_o, bus.rd_o, bus.we_o, bus.icc_o, bus.c1_o, bus.trap_o);
    end
    #2;
    Clr = 1'b1;
    n_vec++;
    if (bus.ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL rst_ready: got %b want 1", bus.ready_o);
    end
    // first edge after release accepts
    bus.ready_i = 1'b1;
    drive(1'b1, 32'h1, 32'h2, 32'h3, 4'b0000, 1'b1, 5'd4, 1'b1);
    step();
    n_vec++;
    if (bus.valid_o !== 1'b1 || bus.y_o !== 32'h3 || bus.icc_o !== 4'b0000) begin
      n_err++;
      $display("FAIL rst_first_accept: got valid=%b y=%h icc=%b want 1/00000003/0000",
               bus.valid_o, bus.y_o, bus.icc_o);
    end
  endtask

  task automatic test_add_carry();
    drive(1'b1, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0000, 1'b1, 5'd5, 1'b1);
    step();
    n_vec++;
    if (bus.y_o !== 32'h0 || bus.rd_o !== 5'd5 || bus.icc_o !== 4'b0101 || bus.c1_o !== 1'b1) begin
      n_err++;
      $display("FAIL add_carry: got y=%h rd=%0d icc=%b c1=%b want 0/5/0101/1",
               bus.y_o, bus.rd_o, bus.icc_o, bus.c1_o);
    end
    // ADDX 0+0+cin(1) = 1, no carry out
    drive(1'b1, 32'h0, 32'h0, 32'h1, 4'b0001, 1'b1, 5'd6, 1'b1);
    step();
    n_vec++;
    if (bus.y_o !== 32'h1 || bus.icc_o !== 4'b0000 || bus.c1_o !== 1'b0) begin
      n_err++;
      $display("FAIL addx_cin: got y=%h icc=%b c1=%b want 00000001/0000/0",
               bus.y_o, bus.icc_o, bus.c1_o);
    end
  endtask

  task automatic test_overflow();
    drive(1'b1, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b0000, 1'b1, 5'd7, 1'b1);
    step();
    n_vec++;
    if (bus.icc_o !== 4'b1010 || bus.trap_o !== TRAP_ON) begin
      n_err++;
      $display("FAIL add_ovf: got icc=%b trap=%b want 1010/%b", bus.icc_o, bus.trap_o, TRAP_ON);
    end
    // retire with nothing behind it
    idle();
    step();
    n_vec++;
    if (bus.valid_o !== 1'b0 || bus.trap_o !== 1'b0 || bus.y_o !== 32'h8000_0000 || bus.icc_o !== 4'b1010) begin
      n_err++;
      $display("FAIL retire: got valid=%b trap=%b y=%h icc=%b want 0/0/80000000/1010",
               bus.valid_o, bus.trap_o, bus.y_o, bus.icc_o);
    end
  endtask

  task automatic test_borrow();
    drive(1'b1, 32'h0, 32'h1, 32'hFFFF_FFFF, 4'b0010, 1'b1, 5'd8, 1'b1);
    step();
    n_vec++;
    if (bus.y_o !== 32'hFFFF_FFFF || bus.icc_o !== 4'b1001 || bus.c1_o !== 1'b1) begin
      n_err++;
      $display("FAIL sub_borrow: got y=%h icc=%b c1=%b want ffffffff/1001/1",
               bus.y_o, bus.icc_o, bus.c1_o);
    end
    // same op, no set_cc: icc unchanged, data still captured
    drive(1'b1, 32'h5, 32'h3, 32'h2, 4'b0010, 1'b0, 5'd8, 1'b1);
    step();
    n_vec++;
    if (bus.y_o !== 32'h2 || bus.icc_o !== 4'b1001) begin
      n_err++;
      $display("FAIL sub_nocc: got y=%h icc=%b want 00000002/1001", bus.y_o, bus.icc_o);
    end
    // SUBX 5-5-cin(1) borrows
    drive(1'b1, 32'h5, 32'h5, 32'hFFFF_FFFF, 4'b0011, 1'b1, 5'd8, 1'b1);
    step();
    n_vec++;
    if (bus.icc_o !== 4'b1001) begin
      n_err++;
      $display("FAIL subx_cin: got icc=%b want 1001", bus.icc_o);
    end
    // signed overflow on subtract: 0x80000000 - 1
    drive(1'b1, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 4'b0010, 1'b1, 5'd8, 1'b1);
    step();
    n_vec++;
    if (bus.icc_o !== 4'b0010 || bus.trap_o !== TRAP_ON) begin
      n_err++;
      $display("FAIL sub_ovf: got icc=%b trap=%b want 0010/%b", bus.icc_o, bus.trap_o, TRAP_ON);
    end
    // logic op: V and C forced to zero
    drive(1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0, 4'b0100, 1'b1, 5'd8, 1'b1);
    step();
    n_vec++;
    if (bus.icc_o !== 4'b0100 || bus.trap_o !== 1'b0) begin
      n_err++;
      $display("FAIL logic_cc: got icc=%b trap=%b want 0100/0", bus.icc_o, bus.trap_o);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 32'h1, 32'h1, 32'h2, 4'b0000, 1'b1, 5'd3, 1'b1);
    step();
    n_vec++;
    if (bus.y_o !== 32'h2 || bus.icc_o !== 4'b0000) begin
      n_err++;
      $display("FAIL stall_load: got y=%h icc=%b want 00000002/0000", bus.y_o, bus.icc_o);
    end
    // downstream blocks; the waiting ALU op would set Z if it were taken
    bus.ready_i = 1'b0;
    drive(1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0, 4'b0100, 1'b1, 5'd11, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0 || bus.y_o !== 32'h2 ||
          bus.rd_o !== 5'd3 || bus.icc_o !== 4'b0000) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got valid=%b ready=%b y=%h rd=%0d icc=%b want 1/0/00000002/3/0000",
                 i, bus.valid_o, bus.ready_o, bus.y_o, bus.rd_o, bus.icc_o);
      end
    end
    // release: replace in the same edge
    bus.ready_i = 1'b1;
    drive(1'b1, 32'h0, 32'h0, 32'h0000_CCCC, 4'b0101, 1'b0, 5'd7, 1'b0);
    #1;
    n_vec++;
    if (bus.ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL stall_release_ready: got %b want 1", bus.ready_o);
    end
    step();
    n_vec++;
    if (bus.valid_o !== 1'b1 || bus.y_o !== 32'h0000_CCCC || bus.rd_o !== 5'd7 || bus.we_o !== 1'b0) begin
      n_err++;
      $display("FAIL stall_replace: got valid=%b y=%h rd=%0d we=%b want 1/0000cccc/7/0",
               bus.valid_o, bus.y_o, bus.rd_o, bus.we_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ys [4];
    logic [4:0]  rds[4];
    ys  = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    rds = '{5'd1, 5'd2, 5'd30, 5'd31};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0, 32'h0, ys[i], 4'b0110, 1'b0, rds[i], i[0]);
      step();
      n_vec++;
      if (bus.valid_o !== 1'b1 || bus.y_o !== ys[i] || bus.rd_o !== rds[i] || bus.we_o !== i[0]) begin
        n_err++;
        $display("FAIL b2b[%0d]: got valid=%b y=%h rd=%0d we=%b want 1/%h/%0d/%b",
                 i, bus.valid_o, bus.y_o, bus.rd_o, bus.we_o, ys[i], rds[i], i[0]);
      end
    end
  endtask

  task automatic test_flush();
    // overflow entry, stalled one cycle
    drive(1'b1, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b0000, 1'b1, 5'd12, 1'b1);
    step();
    bus.ready_i = 1'b0;
    idle();
    step();
    n_vec++;
    if (bus.valid_o !== 1'b1 || bus.trap_o !== TRAP_ON || bus.icc_o !== 4'b1010) begin
      n_err++;
      $display("FAIL flush_pre: got valid=%b trap=%b icc=%b want 1/%b/1010",
               bus.valid_o, bus.trap_o, bus.icc_o, TRAP_ON);
    end
    // flush with a carry-producing accept attempt
    bus.flush_i = 1'b1;
    bus.ready_i = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0000, 1'b1, 5'd13, 1'b1);
    step();
    n_vec++;
    if (bus.valid_o !== 1'b0 || bus.icc_o !== 4'b1010 || bus.trap_o !== 1'b0 || bus.y_o !== 32'h8000_0000) begin
      n_err++;
      $display("FAIL flush_prio: got valid=%b icc=%b trap=%b y=%h want 0/1010/0/80000000",
               bus.valid_o, bus.icc_o, bus.trap_o, bus.y_o);
    end
    bus.flush_i = 1'b0;
    idle();
    step();
    n_vec++;
    if (bus.valid_o !== 1'b0 || bus.icc_o !== 4'b1010) begin
      n_err++;
      $display("FAIL flush_after: got valid=%b icc=%b want 0/1010", bus.valid_o, bus.icc_o);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    Clr = 1'b0;
    bus.flush_i = 1'b0;
    bus.ready_i = 1'b1;
    idle();
    #2;
    test_reset();
    test_add_carry();
    test_overflow();
    test_borrow();
    test_stall();
    test_back_to_back();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/icc_result_stage.md
# icc_result_stage

- Sits directly downstream of `mini_alu` and consumes its 32-bit result `y` together with the ALU's operands and opcode.
- Computes SPARC integer condition codes (N, Z, V, C) and holds them in the architectural icc register.
- Registers the result into a single-entry EX/MEM stage with a valid/ready handshake and flush.
- Drives the ALU's carry input `c1` from the held C flag, closing the ALU's add/sub-with-carry loop.

## Interface
Parameters:
- `DATA_W`, 32, datapath width (a, b, y)
- `RD_W`, 5, destination register index width

Ports:
- `Clk`  in  1  single clock, rising-edge
- `Clr`  in  1  reset, asynchronous, active-low
- `valid_i`  in  1  upstream ALU result valid
- `ready_o`  out  1  stage can accept this cycle
- `a_i`, `b_i`  in  DATA_W  ALU operands (as presented to mini_alu)
- `y_i`  in  DATA_W  ALU result
- `op_i`  in  4  ALU opcode
- `set_cc_i`  in  1  instruction updates icc
- `rd_i`  in  RD_W  destination register
- `we_i`  in  1  register-file write enable
- `flush_i`  in  1  kill held entry and any incoming entry
- `valid_o`  out  1  held entry valid
- `ready_i`  in  1  downstream accepts held entry
- `y_o`  out  DATA_W  held result
- `rd_o`  out  RD_W  held destination
- `we_o`  out  1  held write enable
- `icc_o`  out  4  {N,Z,V,C} architectural flags
- `c1_o`  out  1  carry to ALU `c1`, equal to `icc_o[0]`
- `trap_o`  out  1  overflow trap flag for held entry (see Configuration)

## Operation
- Accept = `valid_i & ready_o & ~flush_i`. `ready_o = ~valid_o | ready_i`.
- Flag rules, using 33-bit arithmetic with `cin` = current C for opcodes 0001/0011 and 0 otherwise:
  - N = `y_i[31]`; Z = (`y_i` == 0).
  - Add (0000/0001): C = bit 32 of `{0,a}+{0,b}+cin`; V = (`a[31]`==`b[31]`) & (`y[31]`!=`a[31]`).
  - Sub (0010/0011): C = borrow = bit 32 of `{0,a}-{0,b}-cin`; V = (`a[31]`!=`b[31]`) & (`y[31]`!=`a[31]`).
  - All other opcodes: V = 0, C = 0.
- icc update: written on accept when `set_cc_i`=1, at the same edge the entry is captured. It is never written at retirement.
- Entry capture on accept: `y_o`, `rd_o`, `we_o` load, `valid_o`←1.
- Retire without a new accept: `valid_o`←0; data fields hold their last value.
- Flush: `valid_o`←0 next edge. A simultaneous accept is dropped and icc is not updated. Flush has priority over every other event.
- Simultaneous retire + accept: the entry is replaced in the same edge, with no bubble.
- Stall (`valid_o`=1, `ready_i`=0): all outputs hold and `ready_o`=0.

## Timing
- Latency: accept edge → `valid_o`=1 on the same edge (1 cycle from `valid_i`).
- Throughput: 1 entry per cycle while `ready_i`=1.
- `icc_o`/`c1_o` reflect the new flags from the cycle after the accept. The next instruction in EX therefore sees the updated C with no forwarding.
- Reset values (asynchronous, on `Clr`=0): `valid_o`=0, `y_o`=0, `rd_o`=0, `we_o`=0, `icc_o`=4'b0000, `c1_o`=0, `trap_o`=0.
- Reset mid-stall discards the held entry. The first edge after `Clr` rises may accept.
- `ready_o` is combinational from `valid_o` and `ready_i` only; no path from `valid_i` to `ready_o`.

## Configuration
- Macro: `ICC_OVF_TRAP_EN`.
- Defined:
  - An accepted entry with `set_cc_i`=1, opcode 0000–0011 and computed V=1 captures trap=1.
  - `trap_o` = stored trap & `valid_o`; it follows the entry through stall and flush.
  - icc is still updated.
- Undefined: `trap_o` is tied to 0 and no trap storage is built.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams (`ALU_ADD`, `ALU_ADDX`, `ALU_SUB`, `ALU_SUBX`, … `ALU_NOTB`)
  - icc bit indices (`ICC_N`=3, `ICC_Z`=2, `ICC_V`=1, `ICC_C`=0)
  - `DATA_W` default
- One combinational sub-module, `icc_calc`:
  - inputs a, b, y, op, cin; output 4-bit flags.
  - reusable by any later stage needing flags.
- Top level: handshake register, icc register, optional trap bit.

## Test plan
- Reset: assert `Clr`=0 mid-stream → all outputs 0 immediately; `ready_o`=1 after release.
- Add carry: a=32'hFFFF_FFFF, b=1, op=0000, set_cc=1 → `y_o`=0, `icc_o`=4'b0101 (Z,C) next cycle, `c1_o`=1. A following op=0001 with a=0, b=0 computes cin=1 and yields C=0.
- Signed overflow: a=32'h7FFF_FFFF, b=1, op=0000, set_cc=1 → `icc_o`=4'b1010. With `ICC_OVF_TRAP_EN`, `trap_o`=1 while the entry is valid.
- Borrow: a=0, b=1, op=0010, set_cc=1 → `y_o`=32'hFFFF_FFFF, `icc_o`=4'b1001. The same op with set_cc=0 leaves `icc_o` unchanged.
- Stall/replace: hold `ready_i`=0 for 3 cycles → `y_o` stable, `ready_o`=0. Raise `ready_i` with `valid_i`=1 → new entry captured the same edge, no bubble.
- Flush priority: `flush_i`=1 with `valid_i`=1, set_cc=1, op=0000 → `valid_o`=0 next cycle and `icc_o` unchanged.
